// File: rtl/pipe_hazard_pkg.sv
// pipe_hazard_pkg
//   Shared types and helpers for the pipeline hazard unit.
//   - sb_entry_t : one scoreboard slot {valid, load, rd}
//   - FWD_RF     : forwarding select value meaning "use the register file"
//   - sel_width  : width of a forwarding select for a given scoreboard depth
//   The rd field is sized for the widest supported register address; narrower
//   addresses are zero-extended before they are stored or compared.
package pipe_hazard_pkg;

  localparam int SB_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic               load;
    logic [SB_RD_W-1:0] rd;
  } sb_entry_t;

  localparam int FWD_RF = 0;

  function automatic int sel_width(input int depth);
    return (depth <= 32'sd1) ? 32'sd1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match
//   Priority search of the scoreboard for one source operand.
//   Ports:
//     entries_i : searchable scoreboard entries, index 0 = youngest (EX)
//     src_i     : source register address (zero-extended)
//     used_i    : source is read and is not r0
//     hit_o     : some searchable entry writes src_i
//     idx_o     : index of the youngest matching entry
//     load_o    : the matching entry is a load
module hazard_match
  import pipe_hazard_pkg::*;
#(
  parameter int NSRCH = 2,
  parameter int IDXW  = 2
) (
  input  sb_entry_t [NSRCH-1:0] entries_i,
  input  logic [SB_RD_W-1:0]    src_i,
  input  logic                  used_i,
  output logic                  hit_o,
  output logic [IDXW-1:0]       idx_o,
  output logic                  load_o
);

  // youngest-first search: the first hit found locks out older entries
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    load_o = 1'b0;
    for (int j = 0; j < NSRCH; j++) begin
      if (!hit_o && used_i && entries_i[j].valid && (entries_i[j].rd == src_i)) begin
        hit_o  = 1'b1;
        idx_o  = IDXW'(j);
        load_o = entries_i[j].load;
      end else begin
        hit_o  = hit_o;
        idx_o  = idx_o;
        load_o = load_o;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
//   Hazard detection and forwarding control for an in-order pipeline.
//   Tracks destination registers of every stage after ID (0 = EX .. DEPTH-1 = WB),
//   decides stall/bubble for the ID instruction and registers the EX operand
//   forwarding selects.
//   Configuration macro: FORWARD_EN
//     defined   : matches are forwarded; only too-young loads stall
//     undefined : any match in stages 0..DEPTH-2 stalls; selects stay 0
//   Ports:
//     clk_i, rst_n_i             : clock, async active-low reset
//     id_valid_i                 : ID holds a real instruction
//     id_rs_i/id_rt_i            : source addresses, with *_used_i qualifiers
//     id_rd_i, id_wr_i, id_load_i: destination, write enable, load flag
//     flush_i                    : squash the ID instruction
//     stall_o                    : hold PC and IF/ID, bubble into EX
//     fwd_a_o/fwd_b_o            : EX operand source (0 = RF, k = stage k)
//     stage_valid_o              : scoreboard valid bits
//     stall_cnt_o                : saturating stall-cycle count
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter  int REG_AW     = 5,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_STAGE = 1,
  parameter  int CNT_W      = 16,
  localparam int SELW       = sel_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rs_used_i,
  input  logic              id_rt_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_wr_i,
  input  logic              id_load_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [SELW-1:0]   fwd_a_o,
  output logic [SELW-1:0]   fwd_b_o,
  output logic [DEPTH-1:0]  stage_valid_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  logic [SELW-1:0]       fwd_a_q, fwd_a_d;
  logic [SELW-1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic                  used_a_s, used_b_s;
  logic                  hit_a_s, hit_b_s;
  logic                  load_a_s, load_b_s;
  logic [SELW-1:0]       idx_a_s, idx_b_s;
  logic                  haz_a_s, haz_b_s;
  logic                  stall_s, issue_s;

  // r0 is never a real dependency
  assign used_a_s = id_rs_used_i & (id_rs_i != {REG_AW{1'b0}});
  assign used_b_s = id_rt_used_i & (id_rt_i != {REG_AW{1'b0}});

  // the oldest entry is excluded: the register file writes through in WB
  hazard_match #(
    .NSRCH (DEPTH-1),
    .IDXW  (SELW)
  ) u_match_a (
    .entries_i (sb_q[DEPTH-2:0]),
    .src_i     (SB_RD_W'(id_rs_i)),
    .used_i    (used_a_s),
    .hit_o     (hit_a_s),
    .idx_o     (idx_a_s),
    .load_o    (load_a_s)
  );

  hazard_match #(
    .NSRCH (DEPTH-1),
    .IDXW  (SELW)
  ) u_match_b (
    .entries_i (sb_q[DEPTH-2:0]),
    .src_i     (SB_RD_W'(id_rt_i)),
    .used_i    (used_b_s),
    .hit_o     (hit_b_s),
    .idx_o     (idx_b_s),
    .load_o    (load_b_s)
  );

  // per-operand hazard, stall and issue decision
  always_comb begin
`ifdef FORWARD_EN
    // a load is only forwardable once it has passed the stage returning its data
    haz_a_s = hit_a_s & load_a_s & ((int'(idx_a_s) + 32'sd1) <= LOAD_STAGE);
    haz_b_s = hit_b_s & load_b_s & ((int'(idx_b_s) + 32'sd1) <= LOAD_STAGE);
`else
    // without forwarding a load match stalls exactly like any other match
    haz_a_s = hit_a_s | (hit_a_s & load_a_s);
    haz_b_s = hit_b_s | (hit_b_s & load_b_s);
`endif
    stall_s = (haz_a_s | haz_b_s) & id_valid_i & ~flush_i;
    issue_s = id_valid_i & ~stall_s & ~flush_i;
  end

  // next scoreboard: shift by one stage, new entry or bubble at EX
  always_comb begin
    for (int k = DEPTH-1; k >= 1; k--) begin
      sb_d[k] = sb_q[k-1];
    end
    if (issue_s && id_wr_i && (id_rd_i != {REG_AW{1'b0}})) begin
      sb_d[0].valid = 1'b1;
      sb_d[0].load  = id_load_i;
      sb_d[0].rd    = SB_RD_W'(id_rd_i);
    end else begin
      sb_d[0] = '0;
    end
  end

  // next forwarding selects, captured as the instruction moves into EX
  always_comb begin
`ifdef FORWARD_EN
    if (issue_s && hit_a_s) begin
      fwd_a_d = SELW'(idx_a_s + 1'b1);
    end else begin
      fwd_a_d = SELW'(FWD_RF);
    end
    if (issue_s && hit_b_s) begin
      fwd_b_d = SELW'(idx_b_s + 1'b1);
    end else begin
      fwd_b_d = SELW'(FWD_RF);
    end
`else
    fwd_a_d = SELW'(FWD_RF);
    fwd_b_d = SELW'(FWD_RF);
`endif
  end

  // saturating stall counter
  always_comb begin
    if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1'b1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // state registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sb_q        <= '0;
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // expose scoreboard valid bits
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_valid_o[k] = sb_q[k].valid;
    end
  end

  assign stall_o     = stall_s;
  assign fwd_a_o     = fwd_a_q;
  assign fwd_b_o     = fwd_b_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard-detection and forwarding controller for the in-order pipeline, replacing the fixed 5-stage load-use detector and the hand-wired forwarding selects. It keeps a scoreboard of destination registers for every stage after ID, decides stall and bubble for the instruction in ID, and produces registered forwarding selects for the operand muxes in EX. It sits beside the ID/EX pipeline register and drives PC write, IF/ID write and bubble insertion.

## Interface
- REG_AW, 5, register address width
- DEPTH, 3, number of tracked stages after ID (index 0 = EX … DEPTH-1 = WB); legal range 3..8
- LOAD_STAGE, 1, stage index at whose end load data returns
- CNT_W, 16, stall-counter width
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  ID holds a real instruction
- id_rs_i, id_rt_i  in  REG_AW  source addresses
- id_rs_used_i, id_rt_used_i  in  1  source actually read
- id_rd_i  in  REG_AW  destination address
- id_wr_i  in  1  instruction writes id_rd_i
- id_load_i  in  1  instruction is a load
- flush_i  in  1  squash the ID instruction (taken branch/jump)
- stall_o  out  1  hold PC and IF/ID, insert bubble into EX
- fwd_a_o, fwd_b_o  out  SELW=$clog2(DEPTH)  EX operand source: 0 = register file, k = stage k result
- stage_valid_o  out  DEPTH  scoreboard valid bits
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Scoreboard: DEPTH entries {valid, rd, load}; all shift one stage per clock (entry DEPTH-1 drops out).
- Entry 0 loads the ID instruction when issue = id_valid_i & !stall_o & !flush_i; otherwise a bubble (valid=0). Valid requires id_wr_i & id_rd_i != 0.
- Per used, non-zero source s: search entries j = 0..DEPTH-2 for valid & rd==s; youngest (lowest j) wins. Entry DEPTH-1 ignored: register file is write-through.
- With forwarding: match at j gives select j+1. Stall if matched entry is a load and j+1 <= LOAD_STAGE.
- stall_o = (stall condition on rs or rt) & id_valid_i & !flush_i. flush_i always wins.
- fwd_a_o/fwd_b_o registered: load computed selects on issue, load 0 on bubble.
- stall_cnt_o increments on each cycle stall_o=1; holds at 2^CNT_W-1.

## Timing
- Reset (async assert, sync-released by top level): all entries invalid, fwd_a_o=fwd_b_o=0, stall_cnt_o=0, stall_o=0.
- stall_o combinational from ID inputs and scoreboard, same cycle.
- fwd selects valid in the cycle the instruction occupies EX (one clock after issue).
- Load-use stall length with defaults: 1 cycle.
- Reset mid-stall: scoreboard cleared, stall drops immediately.

## Configuration
- FORWARD_EN defined: forwarding as above.
- FORWARD_EN undefined: any match in j = 0..DEPTH-2 stalls; fwd_a_o/fwd_b_o tied to 0; LOAD_STAGE unused.

## Structure
- pipe_hazard_pkg: scoreboard entry struct, FWD_RF=0 constant, select-width function.
- Sub-module hazard_match: priority search for one source, returns hit, index, load flag; instantiated twice.

## Test plan
- add r1 issued, then add r2,r1,r3 next cycle -> stall_o=0, fwd_a_o=1 in consumer's EX cycle.
- lw r1, then add r3,r1,r4 -> stall_o=1 for 1 cycle, stall_cnt_o=1, then issue with fwd_a_o=2.
- add r5 at MEM, add r5 at EX, consumer reads r5 on rt -> fwd_b_o=1 (youngest).
- Producer with rd=0 followed by consumer of r0 -> no stall, fwd 0.
- lw r1 then dependent in ID with flush_i=1 -> stall_o=0, bubble enters EX, stage_valid_o[0]=0 next cycle.
- FORWARD_EN undefined, DEPTH=3: add r1 then add r2,r1 -> stall_o=1 for 2 cycles, then issue with fwd_a_o=0.
